// File: rtl/tlp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tlp_tx_arbiter : non-preemptive TLP arbiter sharing one PCIe core TX port
// Revision 1.0
// ============================================================================
module tlp_tx_arbiter #(
    parameter int NPORT     = 3,
    parameter int PRIO0     = 1,
    parameter int MAX_WORDS = 2048
) (
    input  logic                clk_125,
    input  logic                sys_rst_n,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    src_st,
    input  logic [NPORT-1:0]    src_end,
    input  logic [NPORT*16-1:0] src_data,
    output logic [NPORT-1:0]    gnt,
    output logic [NPORT-1:0]    accept,
    output logic                tx_req,
    input  logic                tx_rdy,
    output logic                tx_st,
    output logic                tx_end,
    output logic [15:0]         tx_data,
    output logic                abort_err,
    output logic [15:0]         tlp_cnt
);

    localparam int SELW = (NPORT > 2) ? 2 : 1;
    localparam int WCW  = $clog2(MAX_WORDS + 1);
    localparam logic [WCW-1:0]   WC_LIMIT  = WCW'(MAX_WORDS);
    localparam logic [NPORT-1:0] PRIO_MASK = {{(NPORT-1){1'b0}}, (PRIO0 != 0)};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic            started_q, started_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic            abort_q, abort_d;
    logic [15:0]     tlp_cnt_q, tlp_cnt_d;

    logic [SELW-1:0]  win;
    logic             win_vld;
    logic [SELW-1:0]  cand;
    logic [NPORT-1:0] elig;
    logic [SELW-1:0]  rr_next;
    logic [NPORT-1:0] sel_oh;
    logic [WCW-1:0]   wcnt_inc;
    int               idx;

    assign rr_next  = (sel_q == SELW'(NPORT - 1)) ? '0 : sel_q + SELW'(1);
    assign sel_oh   = NPORT'(1) << sel_q;
    assign wcnt_inc = wcnt_q + WCW'(1);

    // With strict priority, port 0 is handled outside the round-robin scan.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        idx     = 0;
        elig    = req & ~PRIO_MASK;
        for (int k = 0; k < NPORT; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            cand = SELW'(idx);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
        if ((PRIO0 != 0) && req[0]) begin
            win_vld = 1'b1;
            win     = '0;
        end
    end

    always_comb begin
        gnt     = '0;
        accept  = '0;
        tx_req  = 1'b0;
        tx_st   = 1'b0;
        tx_end  = 1'b0;
        tx_data = '0;
        case (state_q)
            REQ: begin
                tx_req = 1'b1;
            end
            XFER: begin
                gnt     = sel_oh;
                accept  = tx_rdy ? sel_oh : '0;
                tx_req  = !started_q;
                tx_st   = src_st[sel_q];
                tx_end  = src_end[sel_q];
                tx_data = src_data[{sel_q, 4'b0000} +: 16];
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_ptr_d  = rr_ptr_q;
        started_d = started_q;
        wcnt_d    = wcnt_q;
        abort_d   = abort_q;
        tlp_cnt_d = tlp_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    sel_d   = win;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (tx_rdy) begin
                    state_d   = XFER;
                    started_d = 1'b0;
                    wcnt_d    = '0;
                end
            end
            XFER: begin
                if (tx_rdy) begin
                    started_d = 1'b1;
                    wcnt_d    = wcnt_inc;
                    // An end word on the limit cycle still completes normally.
                    if (tx_end) begin
                        state_d   = GAP;
                        tlp_cnt_d = tlp_cnt_q + 16'd1;
                        rr_ptr_d  = rr_next;
                    end else if (wcnt_inc == WC_LIMIT) begin
                        state_d  = GAP;
                        abort_d  = 1'b1;
                        rr_ptr_d = rr_next;
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            started_q <= 1'b0;
            wcnt_q    <= '0;
            abort_q   <= 1'b0;
            tlp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            started_q <= started_d;
            wcnt_q    <= wcnt_d;
            abort_q   <= abort_d;
            tlp_cnt_q <= tlp_cnt_d;
        end
    end

    assign abort_err = abort_q;
    assign tlp_cnt   = tlp_cnt_q;

endmodule
`default_nettype wire
